pc_fetch_ctrl: RTL and testbench

- Fetch-stage sequencer for the pipelined MIPS; it drives the PC register's load value and hold control.
- Runs the valid/ack handshake to instruction memory and produces the IF/ID register contents.
- Arbitrates next-PC sources with priority: fault/exception > branch/jump redirect > sequential PC+4.
- Absorbs decode backpressure and kills in-flight fetches on redirect.

---
 rtl/pc_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: arbitrates the next PC, runs the instruction-memory
// valid/ack handshake and fills the IF/ID register, absorbing decode stalls.
module pc_fetch_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_valid,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t      state;
  logic        kill;
  logic [7:0]  wait_cnt;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        active;
  logic        misaligned;
  logic        timeout;
  logic        exc_flush;
  logic        redir;
  logic        flush;
  logic        accept;
  logic [31:0] pc_seq;

  // BOOT ignores every request; the PC is frozen until the first ISSUE.
  assign active     = (state != S_BOOT);
  assign misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign timeout    = imem_req && !imem_ack && (wait_cnt == WAIT_LAST);
  assign exc_flush  = active && (exc_valid || misaligned || timeout);
  assign redir      = active && redirect_valid && !misaligned;
  assign flush      = exc_flush || redir;
  assign accept     = imem_req && imem_ack && !kill && !flush;
  assign pc_seq     = pc_cur + 32'd4;

  // NOTE: pc_next gets its default first so no path through the block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_next = pc_seq;
    if (exc_flush) begin
      pc_next = EXC_VECTOR;
    end else if (redir) begin
      pc_next = redirect_target;
    end
  end

  assign pc_hold = !(flush || accept);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_BOOT;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      fetch_fault <= 1'b0;
      kill        <= 1'b0;
      wait_cnt    <= '0;
      buf_instr   <= '0;
      buf_pc      <= '0;
    end else begin
      fetch_fault <= active && (misaligned || timeout);

      // IF/ID register: flush clears, new data loads, otherwise bubble or hold.
      if (flush) begin
        if_valid <= 1'b0;
      end else if (accept && !id_stall) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= imem_addr;
      end else if ((state == S_HOLD) && !id_stall) begin
        if_valid <= 1'b1;
        if_instr <= buf_instr;
        if_pc    <= buf_pc;
      end else if (!id_stall) begin
        if_valid <= 1'b0;
      end

      case (state)
        S_BOOT: begin
          state <= S_ISSUE;
        end

        S_ISSUE: begin
          if (!flush) begin
            imem_addr <= pc_cur;
            imem_req  <= 1'b1;
            kill      <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            kill     <= 1'b0;
            if (accept && id_stall) begin
              buf_instr <= imem_rdata;
              buf_pc    <= imem_addr;
              state     <= S_HOLD;
            end else begin
              state <= S_ISSUE;
            end
          end else if (timeout) begin
            imem_req <= 1'b0;
            state    <= S_ISSUE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            // The outstanding request must still complete; mark it for discard.
            if (flush) begin
              kill <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (flush || !id_stall) begin
            state <= S_ISSUE;
          end
        end

        default: begin
          state <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl: a transaction-level model predicts the
// PC control per cycle and queues every IF/ID delivery for a separate monitor.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] EXC   = 32'h0000_0180;
  localparam int          LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  pc_fetch_ctrl #(.EXC_VECTOR(EXC), .WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
    .pc_hold(pc_hold), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t exp_q[$];

  // Reference model: the fetch is a transaction that is either being
  // issued, outstanding in memory, or parked waiting for decode.
  bit          m_boot, m_issue, m_inflight, m_doomed, m_holding;
  int          m_age;
  logic [31:0] m_pc, m_addr, m_buf_pc, m_buf_instr;
  bit          m_ifv, m_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_issue = 0; m_inflight = 0; m_doomed = 0; m_holding = 0;
    m_age = 0; m_addr = '0; m_buf_pc = '0; m_buf_instr = '0;
    m_ifv = 0; m_fault = 0;
    exp_q.delete();
  endtask

  task automatic drive(input int ack_pct, input bit quiet);
    logic [31:0] t;
    imem_ack   = ($urandom_range(99) < ack_pct);
    imem_rdata = $urandom;
    id_stall   = ($urandom_range(99) < 30);
    t = $urandom & 32'h0000_0FFC;
    if ($urandom_range(2) == 0) t[1:0] = 2'($urandom_range(3, 1));
    redirect_target = t;
    redirect_valid  = !quiet && !m_boot && ($urandom_range(99) < 8);
    exc_valid       = !quiet && !m_boot && ($urandom_range(99) < 3);
  endtask

  // Check this cycle's outputs, advance the model across the coming edge,
  // then wait for the next falling edge.
  task automatic step();
    bit          mis, to, excf, red, fl, acc, exp_hold;
    logic [31:0] exp_next;
    fetch_t      e;
    pc_cur = m_pc;
    #1;
    mis  = !m_boot && redirect_valid && (redirect_target[1:0] != 2'b00);
    to   = m_inflight && !imem_ack && (m_age == LIMIT - 1);
    excf = !m_boot && (exc_valid || mis || to);
    red  = !m_boot && redirect_valid && !mis;
    fl   = excf || red;
    acc  = m_inflight && imem_ack && !fl && !m_doomed;
    exp_hold = !(fl || acc);
    exp_next = excf ? EXC : (red ? redirect_target : m_pc + 32'd4);

    check("pc_hold", 32'(pc_hold), 32'(exp_hold));
    if (!exp_hold) check("pc_next", pc_next, exp_next);
    check("imem_req", 32'(imem_req), 32'(m_inflight));
    if (m_inflight) check("imem_addr", imem_addr, m_addr);
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    check("if_valid", 32'(if_valid), 32'(m_ifv));

    m_fault = mis || to;

    if (fl) begin
      m_ifv = 0;
    end else if (acc && !id_stall) begin
      m_ifv = 1; e.pc = m_addr; e.instr = imem_rdata; exp_q.push_back(e);
    end else if (m_holding && !id_stall) begin
      m_ifv = 1; e.pc = m_buf_pc; e.instr = m_buf_instr; exp_q.push_back(e);
    end else if (!id_stall) begin
      m_ifv = 0;
    end

    if (m_boot) begin
      m_boot = 0; m_issue = 1;
    end else if (m_issue) begin
      if (!fl) begin
        m_issue = 0; m_inflight = 1; m_addr = m_pc; m_age = 0; m_doomed = 0;
      end
    end else if (m_inflight) begin
      if (imem_ack) begin
        m_inflight = 0;
        if (acc && id_stall) begin
          m_holding = 1; m_buf_pc = m_addr; m_buf_instr = imem_rdata;
        end else begin
          m_issue = 1;
        end
      end else if (to) begin
        m_inflight = 0; m_issue = 1;
      end else begin
        m_age++;
        if (fl) m_doomed = 1;
      end
    end else if (m_holding) begin
      if (fl || !id_stall) begin
        m_holding = 0; m_issue = 1;
      end
    end

    if (!exp_hold) m_pc = exp_next;
    @(negedge clk);
  endtask

  // Monitor: a fresh IF/ID word is present whenever if_valid is set after an
  // edge at which decode was accepting.
  logic stall_at_edge = 1'b1;
  always @(posedge clk) stall_at_edge <= id_stall;

  always @(negedge clk) begin
    fetch_t e;
    if (!reset && if_valid && !stall_at_edge) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL if_delivery: got if_pc=%h if_instr=%h, expected no delivery", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_instr", if_instr, e.instr);
      end
    end
  end

  initial begin
    reset = 1'b1; pc_cur = '0; imem_ack = 0; imem_rdata = '0; id_stall = 0;
    redirect_valid = 0; redirect_target = '0; exc_valid = 0;
    m_pc = '0;
    model_reset();
    #2;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    check("rst_pc_hold", 32'(pc_hold), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin drive(45, 1); step(); end
    for (int i = 0; i < 800; i++) begin drive(45, 0); step(); end
    for (int i = 0; i < 300; i++) begin drive(15, 0); step(); end

    // Steer the PC to the top of the address space to exercise the wrap.
    drive(45, 1);
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    step();
    for (int i = 0; i < 40; i++) begin drive(60, 1); step(); end

    // Reset in the middle of an outstanding request.
    for (int i = 0; i < 50 && !m_inflight; i++) begin drive(0, 1); step(); end
    check("reach_wait", 32'(m_inflight), 32'd1);
    m_pc = 32'h10; pc_cur = 32'h10;
    reset = 1'b1;
    #1;
    check("midrst_imem_req", 32'(imem_req), 32'd0);
    check("midrst_if_valid", 32'(if_valid), 32'd0);
    check("midrst_pc_hold", 32'(pc_hold), 32'd1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin drive(45, 1); step(); end
    for (int i = 0; i < 600; i++) begin drive(45, 0); step(); end

    #2;
    check("pending_deliveries", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
